// File: rtl/uart_link_pkg.sv
// uart_link_pkg: FSM states and line constants shared by the UART link receiver and transmitter
package uart_link_pkg;
  typedef enum logic [1:0] {IDLE, DATA, TRAIL, GUARD} rx_state_t;
  localparam int DEFAULT_DATA_BITS = 8;
  localparam logic TRAILER_BIT = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/receive_if.sv
// receive_if: serial line, link enable and word handshake between line driver/consumer and receiver
interface receive_if #(parameter int DATA_BITS = uart_link_pkg::DEFAULT_DATA_BITS);
  logic connection_status, rxd, rx_ack, rx_valid, frame_error, overrun;
  logic [DATA_BITS-1:0] rx_word;
  modport master (output connection_status, rxd, rx_ack, input rx_word, rx_valid, frame_error, overrun);
  modport slave (input connection_status, rxd, rx_ack, output rx_word, rx_valid, frame_error, overrun);
endinterface

// File: rtl/rx_sync.sv
// rx_sync: idle-level synchronizer; primed rises once the chain holds only real line samples
module rx_sync import uart_link_pkg::*; #(parameter int SYNC_STAGES = 2) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic primed
);
  logic [SYNC_STAGES-1:0] ff, fill;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ff <= {SYNC_STAGES{IDLE_LEVEL}};
      fill <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  assign q = ff[SYNC_STAGES-1];
  assign primed = fill[SYNC_STAGES-1];
endmodule

// File: rtl/receive.sv
// receive: one-bit-per-clock frame receiver with single-word holding register, overrun and framing checks
module receive import uart_link_pkg::*; #(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  receive_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS + 1);
  rx_state_t state;
  logic rxd_s, primed, publish;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] sh, word;
  logic valid, ferr, ovr;
  rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(bus.rxd), .q(rxd_s), .primed(primed));
  assign publish = state == TRAIL && rxd_s == TRAILER_BIT;
  // GUARD waits for primed so reset-forced idle levels never count as a guard bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= GUARD;
      cnt <= '0;
      sh <= '0;
      word <= '0;
      valid <= 1'b0;
      ferr <= 1'b0;
      ovr <= 1'b0;
    end else if (!bus.connection_status) begin
      state <= GUARD;
      cnt <= '0;
      sh <= '0;
      ferr <= 1'b0;
    end else begin
      ferr <= state == TRAIL && rxd_s != TRAILER_BIT;
      case (state)
        IDLE: if (rxd_s != IDLE_LEVEL) begin
          state <= DATA;
          cnt <= '0;
        end
        DATA: begin
          sh <= DATA_BITS'({rxd_s, sh} >> 1);
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_BITS - 1)) state <= TRAIL;
        end
        TRAIL: state <= GUARD;
        default: if (primed && rxd_s == IDLE_LEVEL) state <= IDLE;
      endcase
      if (publish && (!valid || bus.rx_ack)) begin
        word <= sh;
        valid <= 1'b1;
      end else if (publish) ovr <= 1'b1;
      else if (valid && bus.rx_ack) begin
        valid <= 1'b0;
        ovr <= 1'b0;
      end
    end
  assign bus.rx_word = word;
  assign bus.rx_valid = valid;
  assign bus.frame_error = ferr;
  assign bus.overrun = ovr;
endmodule
